// File: rtl/latch_write_ctrl_pkg.sv
// Shared types and timing defaults for the latch write controller.
package latch_pkg;

  // Phases of one latch write: present D, open the latch, keep D after closing.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Width of a down-counter able to hold the largest phase length minus one.
  // Never returns less than 1 so a bad parameter set still elaborates far
  // enough to report its own error.
  function automatic int cnt_width(input int setup_cyc, input int pulse_cyc,
                                   input int hold_cyc);
    int max_cyc;
    max_cyc = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
    max_cyc = (hold_cyc > max_cyc) ? hold_cyc : max_cyc;
    return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/latch_write_ctrl_if.sv
// Producer handshake plus latch-side outputs of the latch write controller.
interface latch_write_ctrl_if
  import latch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] lat_d;
  logic             lat_en;
  logic             busy;
  logic             done;

  // Producer / observer side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  lat_d,
    input  lat_en,
    input  busy,
    input  done
  );

  // Controller side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output lat_d,
    output lat_en,
    output busy,
    output done
  );

endinterface

// File: rtl/latch_write_ctrl.sv
// Write-side driver for level-sensitive D latches: accepts a word, holds it on
// lat_d, then opens lat_en with fixed setup / pulse / hold margins in cycles.
module latch_write_ctrl
  import latch_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input logic               clk,
  input logic               rst_n,
  latch_write_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  // Every phase must last at least one cycle, otherwise the latch margins vanish.
  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $error("latch_write_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_lat_d;
  logic [WIDTH-1:0] w_lat_d_nxt;
  logic             r_lat_en;
  logic             w_lat_en_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // State and all latch-facing outputs are registered; reset closes the latch at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= CNT_ZERO;
      r_lat_d  <= {WIDTH{1'b0}};
      r_lat_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lat_d  <= w_lat_d_nxt;
      r_lat_en <= w_lat_en_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Phase sequencing; lat_d is only loaded on acceptance so it is stable
  // for the whole transparent window and the hold phase.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lat_d_nxt  = r_lat_d;
    w_lat_en_nxt = r_lat_en;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_lat_d_nxt = bus.in_data;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = SETUP_LOAD;
          w_state_nxt = SETUP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (r_cnt == CNT_ZERO) begin
          w_lat_en_nxt = 1'b1;
          w_cnt_nxt    = PULSE_LOAD;
          w_state_nxt  = PULSE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      PULSE: begin
        if (r_cnt == CNT_ZERO) begin
          w_lat_en_nxt = 1'b0;
          w_cnt_nxt    = HOLD_LOAD;
          w_state_nxt  = HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (r_cnt == CNT_ZERO) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_lat_en_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_cnt_nxt    = CNT_ZERO;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.lat_d    = r_lat_d;
  assign bus.lat_en   = r_lat_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Bench for latch_write_ctrl: two instances (default and 3/1/2 timing), a
// timeline-based reference model, a behavioural D latch on each output pair,
// directed literal checks and randomized traffic.
module tb_latch_write_ctrl;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  latch_write_ctrl_if #(.WIDTH(8)) bus_a ();
  latch_write_ctrl_if #(.WIDTH(8)) bus_b ();

  latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural d_latch attached to each controller.
  logic [7:0] q_a;
  logic [7:0] q_b;
  always_latch begin
    if (bus_a.lat_en) q_a <= bus_a.lat_d;
  end
  always_latch begin
    if (bus_b.lat_en) q_b <= bus_b.lat_d;
  end

  // Per-instance views so the model and comparer can loop.
  int         sp [2] = '{1, 3};
  int         pp [2] = '{2, 1};
  int         hp [2] = '{1, 2};
  logic       a_valid [2];
  logic [7:0] a_data  [2];
  logic       a_ready [2];
  logic [7:0] a_lat_d [2];
  logic       a_lat_en[2];
  logic       a_busy  [2];
  logic       a_done  [2];
  logic [7:0] a_q     [2];

  always_comb begin
    a_valid[0] = bus_a.in_valid;  a_valid[1] = bus_b.in_valid;
    a_data[0]  = bus_a.in_data;   a_data[1]  = bus_b.in_data;
    a_ready[0] = bus_a.in_ready;  a_ready[1] = bus_b.in_ready;
    a_lat_d[0] = bus_a.lat_d;     a_lat_d[1] = bus_b.lat_d;
    a_lat_en[0] = bus_a.lat_en;   a_lat_en[1] = bus_b.lat_en;
    a_busy[0]  = bus_a.busy;      a_busy[1]  = bus_b.busy;
    a_done[0]  = bus_a.done;      a_done[1]  = bus_b.done;
    a_q[0]     = q_a;             a_q[1]     = q_b;
  end

  // Model: m_t = clock edges since the last accepted word (-1 = none since reset).
  int         m_t [2] = '{-1, -1};
  logic [7:0] m_d [2] = '{8'h00, 8'h00};

  function automatic logic m_busy(input int i);
    return (m_t[i] >= 0) && (m_t[i] < sp[i] + pp[i] + hp[i]);
  endfunction

  function automatic logic m_en(input int i);
    return (m_t[i] >= sp[i]) && (m_t[i] < sp[i] + pp[i]);
  endfunction

  function automatic logic m_done(input int i);
    return (m_t[i] == sp[i] + pp[i] + hp[i]);
  endfunction

  task automatic chk(input string name, input int dut, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, dut, $time, act, exp);
    end
  endtask

  // Advance the model timeline on each clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_t[i] <= -1;
        m_d[i] <= 8'h00;
      end else if (!m_busy(i) && a_valid[i]) begin
        m_t[i] <= 0;
        m_d[i] <= a_data[i];
      end else if (m_t[i] >= 0 && m_t[i] <= sp[i] + pp[i] + hp[i]) begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_lat_d", i, 32'(a_lat_d[i]), 32'h0);
        chk("rst_lat_en", i, 32'(a_lat_en[i]), 32'h0);
        chk("rst_busy", i, 32'(a_busy[i]), 32'h0);
        chk("rst_done", i, 32'(a_done[i]), 32'h0);
      end else begin
        chk("in_ready", i, 32'(a_ready[i]), 32'(!m_busy(i)));
        chk("lat_d", i, 32'(a_lat_d[i]), 32'(m_d[i]));
        chk("lat_en", i, 32'(a_lat_en[i]), 32'(m_en(i)));
        chk("busy", i, 32'(a_busy[i]), 32'(m_busy(i)));
        chk("done", i, 32'(a_done[i]), 32'(m_done(i)));
        if (m_done(i)) chk("latch_q", i, 32'(a_q[i]), 32'(m_d[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_lat_d", 0, 32'(bus_a.lat_d), 32'h0);
    chk("lit_rst_lat_en", 0, 32'(bus_a.lat_en), 32'h0);
    chk("lit_rst_busy", 0, 32'(bus_a.busy), 32'h0);
    chk("lit_rst_done", 0, 32'(bus_a.done), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("lit_ready_after_rst", 0, 32'(bus_a.in_ready), 32'h1);
    chk("lit_ready_after_rst", 1, 32'(bus_b.in_ready), 32'h1);

    // Single write of A5 on the default instance.
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA5;
    step(); // E0
    chk("lit_e0_lat_d", 0, 32'(bus_a.lat_d), 32'hA5);
    chk("lit_e0_lat_en", 0, 32'(bus_a.lat_en), 32'h0);
    chk("lit_e0_busy", 0, 32'(bus_a.busy), 32'h1);
    chk("lit_e0_ready", 0, 32'(bus_a.in_ready), 32'h0);
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00;
    step(); // E1
    chk("lit_e1_lat_en", 0, 32'(bus_a.lat_en), 32'h1);
    step(); // E2
    chk("lit_e2_lat_en", 0, 32'(bus_a.lat_en), 32'h1);
    chk("lit_e2_lat_d", 0, 32'(bus_a.lat_d), 32'hA5);
    step(); // E3
    chk("lit_e3_lat_en", 0, 32'(bus_a.lat_en), 32'h0);
    chk("lit_e3_done", 0, 32'(bus_a.done), 32'h0);
    step(); // E4
    chk("lit_e4_done", 0, 32'(bus_a.done), 32'h1);
    chk("lit_e4_q", 0, 32'(q_a), 32'hA5);
    step(); // E5
    chk("lit_e5_done", 0, 32'(bus_a.done), 32'h0);

    // Back-to-back with in_valid held: A5, 3C, FF accepted at E0, E5, E10.
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA5;
    step(); // E0
    bus_a.in_data = 8'h3C;
    repeat (4) step(); // E4
    chk("lit_b2b_done1", 0, 32'(bus_a.done), 32'h1);
    chk("lit_b2b_hold_a5", 0, 32'(bus_a.lat_d), 32'hA5);
    step(); // E5
    chk("lit_b2b_lat_d2", 0, 32'(bus_a.lat_d), 32'h3C);
    bus_a.in_data = 8'hFF;
    repeat (4) step(); // E9
    chk("lit_b2b_done2", 0, 32'(bus_a.done), 32'h1);
    step(); // E10
    chk("lit_b2b_lat_d3", 0, 32'(bus_a.lat_d), 32'hFF);
    bus_a.in_valid = 1'b0;
    repeat (4) step(); // E14
    chk("lit_b2b_done3", 0, 32'(bus_a.done), 32'h1);
    chk("lit_b2b_q", 0, 32'(q_a), 32'hFF);
    step();

    // Reset while the latch is open.
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h5A;
    step(); // E0
    bus_a.in_valid = 1'b0;
    step(); // E1
    chk("lit_pre_rst_lat_en", 0, 32'(bus_a.lat_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_lat_en", 0, 32'(bus_a.lat_en), 32'h0);
    chk("lit_midrst_lat_d", 0, 32'(bus_a.lat_d), 32'h0);
    chk("lit_midrst_busy", 0, 32'(bus_a.busy), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h96;
    step(); // E0
    bus_a.in_valid = 1'b0;
    repeat (4) step(); // E4
    chk("lit_after_rst_done", 0, 32'(bus_a.done), 32'h1);
    chk("lit_after_rst_q", 0, 32'(q_a), 32'h96);
    step();

    // Non-default timing 3/1/2 on the second instance.
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'hC3;
    step(); // E0
    bus_b.in_valid = 1'b0;
    step(); step(); // E2
    chk("lit_b_e2_lat_en", 1, 32'(bus_b.lat_en), 32'h0);
    step(); // E3
    chk("lit_b_e3_lat_en", 1, 32'(bus_b.lat_en), 32'h1);
    step(); // E4
    chk("lit_b_e4_lat_en", 1, 32'(bus_b.lat_en), 32'h0);
    step(); // E5
    chk("lit_b_e5_done", 1, 32'(bus_b.done), 32'h0);
    step(); // E6
    chk("lit_b_e6_done", 1, 32'(bus_b.done), 32'h1);
    chk("lit_b_e6_q", 1, 32'(q_b), 32'hC3);
    step();

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      bus_a.in_valid = 1'($urandom_range(0, 1));
      bus_a.in_data  = 8'($urandom);
      bus_b.in_valid = ($urandom_range(0, 3) != 0);
      bus_b.in_data  = 8'($urandom);
      step();
    end
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
